// File: rtl/cv32e40p_regfile_sb.sv
// cv32e40p_regfile_sb
// Multi-ported register file with a per-register scoreboard. The
// scoreboard marks destinations that a long-latency producer has reserved
// and clears the mark when the result is written back.
//
// Address MSB selects the bank: 0 is the integer bank, 1 is the FP bank.
// The FP bank exists only when FPU=1 and ZFINX=0. Register x0 of the
// integer bank is hardwired to zero and is never pending.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   raddr_i        NUM_RPORTS read addresses, port k in slice k
//   rdata_o        combinational read data per port
//   rbusy_o        pending bit of the addressed register per port
//   waddr_i        NUM_WPORTS write addresses
//   wdata_i        NUM_WPORTS write data words
//   we_i           write enables; highest enabled port wins on a collision
//   rsv_addr_i     destination being reserved
//   rsv_valid_i    reservation request
//   pend_o         pending bit per register
//   busy_cnt_o     registered count of pending registers
//   rsv_err_o      sticky: reservation of an already-pending register
module cv32e40p_regfile_sb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0,
    parameter int ZFINX      = 0,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rbusy_o,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WPORTS-1:0]            we_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    input  logic                             rsv_valid_i,
    output logic [2**ADDR_WIDTH-1:0]         pend_o,
    output logic [ADDR_WIDTH:0]              busy_cnt_o,
    output logic                             rsv_err_o
);

    localparam int NUM_WORDS = 2**(ADDR_WIDTH-1);
    localparam int NUM_REGS  = 2*NUM_WORDS;
    localparam bit FP_BANK   = (FPU == 1) && (ZFINX == 0);

    // An address is live if it is not x0 and its bank is implemented.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (FP_BANK || !a[ADDR_WIDTH-1]);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic [NUM_REGS-1:0]   wr_hit, rsv_hit;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;

    // Write merge: ports are visited in ascending order so the highest
    // enabled port's data is what remains in mem_d.
    always_comb begin
        mem_d  = mem_q;
        wr_hit = '0;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (we_i[p] && addr_ok(waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                mem_d[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]]  = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                wr_hit[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
    end

    // Scoreboard next state. A reservation takes priority over a
    // same-cycle write so the new producer keeps ownership of the bit.
    always_comb begin
        rsv_hit = '0;
        if (rsv_valid_i && addr_ok(rsv_addr_i)) begin
            rsv_hit[rsv_addr_i] = 1'b1;
        end
        pend_d = (pend_q & ~wr_hit) | rsv_hit;
        err_d  = err_q | (|(rsv_hit & pend_q & ~wr_hit));
        cnt_d  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
        end
    end

    // Read ports. With forwarding, a read of an address being written
    // this cycle sees the winning write data and is reported not busy.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int k = 0; k < NUM_RPORTS; k++) begin
            if (addr_ok(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
                if ((BYPASS == 1) && wr_hit[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]]) begin
                    rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_d[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
                    rbusy_o[k] = 1'b0;
                end else begin
                    rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
                    rbusy_o[k] = pend_q[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign pend_o     = pend_q;
    assign busy_cnt_o = cnt_q;
    assign rsv_err_o  = err_q;

endmodule

// File: tb/tb_cv32e40p_regfile_sb.sv
module tb_cv32e40p_regfile_sb;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata, rdata_nb;
    logic [NR-1:0]    rbusy, rbusy_nb;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW-1:0]    we;
    logic [AW-1:0]    rsv_addr;
    logic             rsv_valid;
    logic [63:0]      pend, pend_nb;
    logic [AW:0]      cnt, cnt_nb;
    logic             err, err_nb;

    cv32e40p_regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_addr_i(rsv_addr),
        .rsv_valid_i(rsv_valid), .pend_o(pend), .busy_cnt_o(cnt), .rsv_err_o(err)
    );

    cv32e40p_regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_nb), .rbusy_o(rbusy_nb),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_addr_i(rsv_addr),
        .rsv_valid_i(rsv_valid), .pend_o(pend_nb), .busy_cnt_o(cnt_nb), .rsv_err_o(err_nb)
    );

    typedef struct {
        logic [1:0]  we;
        logic [5:0]  wa0;
        logic [31:0] wd0;
        logic [5:0]  wa1;
        logic [31:0] wd1;
        logic        rv;
        logic [5:0]  ra;
        logic [5:0]  rd;
        logic [31:0] exp_rdata;
        logic        exp_rbusy;
        logic [63:0] exp_pend;
        logic [6:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] P9  = 64'h200;
    localparam logic [63:0] P10 = 64'h400;
    localparam logic [63:0] P12 = 64'h1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] w, input logic [5:0] a0, input logic [31:0] d0,
                       input logic [5:0] a1, input logic [31:0] d1, input logic rv,
                       input logic [5:0] ra, input logic [5:0] rd, input logic [31:0] er,
                       input logic eb, input logic [63:0] ep, input logic [6:0] ec,
                       input logic ee);
        vec_t v;
        v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1; v.rv = rv; v.ra = ra;
        v.rd = rd; v.exp_rdata = er; v.exp_rbusy = eb; v.exp_pend = ep; v.exp_cnt = ec;
        v.exp_err = ee;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        we = '0; waddr = '0; wdata = '0; rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        idle_inputs();
        raddr = '0;

        // Columns: we, wa0, wd0, wa1, wd1, rsv_valid, rsv_addr, read addr (port 1),
        // expected rdata/rbusy (combinational), pend/cnt/err (state before the edge).
        add(2'b00, 0,     0,      0,  0,      0, 0,     5,     0,      0, 0,       0, 0);
        add(2'b01, 5,     'h1234, 0,  0,      0, 0,     1,     0,      0, 0,       0, 0);
        add(2'b00, 0,     0,      0,  0,      0, 0,     5,     'h1234, 0, 0,       0, 0);
        add(2'b11, 7,     'hAAAA, 7,  'h5555, 0, 0,     7,     'h5555, 0, 0,       0, 0);
        add(2'b00, 0,     0,      0,  0,      0, 0,     7,     'h5555, 0, 0,       0, 0);
        add(2'b01, 3,     'hBEEF, 0,  0,      0, 0,     3,     'hBEEF, 0, 0,       0, 0);
        add(2'b00, 0,     0,      0,  0,      1, 9,     9,     0,      0, 0,       0, 0);
        add(2'b00, 0,     0,      0,  0,      0, 0,     9,     0,      1, P9,      1, 0);
        add(2'b00, 0,     0,      0,  0,      0, 0,     9,     0,      1, P9,      1, 0);
        add(2'b00, 0,     0,      0,  0,      0, 0,     9,     0,      1, P9,      1, 0);
        add(2'b10, 0,     0,      9,  'h42,   0, 0,     9,     'h42,   0, P9,      1, 0);
        add(2'b00, 0,     0,      0,  0,      0, 0,     9,     'h42,   0, 0,       0, 0);
        add(2'b00, 0,     0,      0,  0,      1, 9,     9,     'h42,   0, 0,       0, 0);
        add(2'b00, 0,     0,      0,  0,      1, 9,     9,     'h42,   1, P9,      1, 0);
        add(2'b01, 0,     'hFFFF, 0,  0,      0, 0,     0,     0,      0, P9,      1, 1);
        add(2'b00, 0,     0,      0,  0,      0, 0,     0,     0,      0, P9,      1, 1);
        add(2'b01, 10,    'h10,   0,  0,      1, 10,    10,    'h10,   0, P9,      1, 1);
        add(2'b00, 0,     0,      0,  0,      0, 0,     10,    'h10,   1, P9|P10,  2, 1);
        add(2'b10, 0,     0,      10, 'h11,   1, 12,    12,    0,      0, P9|P10,  2, 1);
        add(2'b00, 0,     0,      0,  0,      0, 0,     10,    'h11,   0, P9|P12,  2, 1);
        add(2'b01, 'h21,  'h77,   0,  0,      1, 'h21,  'h21,  0,      0, P9|P12,  2, 1);
        add(2'b00, 0,     0,      0,  0,      0, 0,     'h21,  0,      0, P9|P12,  2, 1);
        add(2'b11, 9,     1,      12, 2,      0, 0,     12,    2,      0, P9|P12,  2, 1);
        add(2'b00, 0,     0,      0,  0,      0, 0,     9,     1,      0, 0,       0, 1);

        // Reset state
        #2;
        check("rst_pend", pend, 0);
        check("rst_cnt", {57'd0, cnt}, 0);
        check("rst_err", {63'd0, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            we        = vq[i].we;
            waddr     = {vq[i].wa1, vq[i].wa0};
            wdata     = {vq[i].wd1, vq[i].wd0};
            rsv_valid = vq[i].rv;
            rsv_addr  = vq[i].ra;
            raddr     = {6'd7, vq[i].rd, 6'd5};
            #2;
            check($sformatf("v%0d_rdata", i), {32'd0, rdata[DW +: DW]}, {32'd0, vq[i].exp_rdata});
            check($sformatf("v%0d_rbusy", i), {63'd0, rbusy[1]}, {63'd0, vq[i].exp_rbusy});
            check($sformatf("v%0d_pend", i), pend, vq[i].exp_pend);
            check($sformatf("v%0d_cnt", i), {57'd0, cnt}, {57'd0, vq[i].exp_cnt});
            check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vq[i].exp_err});
        end

        // Reset asserted mid-cycle while a write and reservations are driven.
        @(negedge clk);
        we = 2'b11; waddr = {6'h21, 6'd6}; wdata = {32'h77, 32'h66};
        rsv_valid = 1'b1; rsv_addr = 6'd5;
        raddr = {6'd5, 6'h21, 6'd7};
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_rdata0", {32'd0, rdata[0 +: DW]}, 0);
        check("rstmid_rdata2", {32'd0, rdata[2*DW +: DW]}, 0);
        check("rstmid_pend", pend, 0);
        check("rstmid_cnt", {57'd0, cnt}, 0);
        check("rstmid_err", {63'd0, err}, 0);
        @(posedge clk);
        #1;
        check("rstedge_pend", pend, 0);
        check("rstedge_rdata0", {32'd0, rdata[0 +: DW]}, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        raddr = {6'd5, 6'h21, 6'd6};
        #2;
        check("post_x6", {32'd0, rdata[0 +: DW]}, 0);
        check("post_x21", {32'd0, rdata[DW +: DW]}, 0);
        check("post_x21_busy", {63'd0, rbusy[1]}, 0);
        check("post_x5_busy", {63'd0, rbusy[2]}, 0);
        @(posedge clk);
        #1;
        check("post_pend", pend, 0);

        // Forwarding on vs off: reserve x4, then write it while reading it.
        @(negedge clk);
        rsv_valid = 1'b1; rsv_addr = 6'd4;
        raddr = {6'd0, 6'd4, 6'd0};
        @(negedge clk);
        rsv_valid = 1'b0;
        we = 2'b01; waddr = {6'd0, 6'd4}; wdata = {32'd0, 32'h99};
        #2;
        check("byp_rdata", {32'd0, rdata[DW +: DW]}, 'h99);
        check("byp_rbusy", {63'd0, rbusy[1]}, 0);
        check("nobyp_rdata", {32'd0, rdata_nb[DW +: DW]}, 0);
        check("nobyp_rbusy", {63'd0, rbusy_nb[1]}, 1);
        @(negedge clk);
        idle_inputs();
        #2;
        check("nobyp_after", {32'd0, rdata_nb[DW +: DW]}, 'h99);
        check("nobyp_after_busy", {63'd0, rbusy_nb[1]}, 0);
        check("nobyp_cnt", {57'd0, cnt_nb}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
